// File: rtl/ram_dbg_pkg.sv
// Shared types for the debug RAM bridge: access size, FSM state and the
// per-beat address step.
package ram_dbg_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_BAD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   // Byte distance between consecutive auto-increment beats.
   function automatic logic [31:0] size_step(input size_e size);
      return 32'd1 << size;
   endfunction

endpackage

// File: rtl/ram_dbg_bridge_if.sv
// Command/response channel from the debug module plus the RAM jtag_* access
// port. The bridge uses the slave view; the debug side and RAM use master.
interface ram_dbg_bridge_if #(
   parameter int unsigned LEN_W = 8
);
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic             cmd_we_i;
   logic [31:0]      cmd_addr_i;
   logic [31:0]      cmd_wdata_i;
   logic [1:0]       cmd_size_i;
   logic [LEN_W-1:0] cmd_len_i;
   logic             cmd_autoinc_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [31:0]      rsp_rdata_o;
   logic             rsp_err_o;
   logic             rsp_last_o;
   logic             busy_o;
   logic             lsu_wr_i;
   logic             jtag_ce_o;
   logic             jtag_we_o;
   logic [3:0]       jtag_sel_o;
   logic [31:0]      jtag_addr_o;
   logic [31:0]      jtag_data_o;
   logic             jtag_rvalid_i;
   logic [31:0]      jtag_data_i;

   modport slave (
      input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_size_i,
             cmd_len_i, cmd_autoinc_i, rsp_ready_i, lsu_wr_i,
             jtag_rvalid_i, jtag_data_i,
      output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
             busy_o, jtag_ce_o, jtag_we_o, jtag_sel_o, jtag_addr_o, jtag_data_o
   );

   modport master (
      output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i, cmd_size_i,
             cmd_len_i, cmd_autoinc_i, rsp_ready_i, lsu_wr_i,
             jtag_rvalid_i, jtag_data_i,
      input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
             busy_o, jtag_ce_o, jtag_we_o, jtag_sel_o, jtag_addr_o, jtag_data_o
   );
endinterface

// File: rtl/ram_dbg_lane.sv
// Byte-lane handling for one access: lane enables, write-data replication,
// read-data extraction with zero extension, and alignment check.
module ram_dbg_lane
   import ram_dbg_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata_in,
   input  logic [31:0] rword,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [31:0] shifted;

   // Decode lanes for the current size/offset; illegal size yields no lanes.
   always_comb begin
      shifted  = rword >> {lane, 3'b000};
      sel      = '0;
      wdata    = '0;
      rdata    = '0;
      misalign = 1'b0;
      case (size)
         SZ_B: begin
            sel   = 4'b0001 << lane;
            wdata = {4{wdata_in[7:0]}};
            rdata = {24'd0, shifted[7:0]};
         end
         SZ_H: begin
            sel      = 4'b0011 << lane;
            wdata    = {2{wdata_in[15:0]}};
            rdata    = {16'd0, shifted[15:0]};
            misalign = lane[0];
         end
         SZ_W: begin
            sel      = 4'b1111;
            wdata    = wdata_in;
            rdata    = rword;
            misalign = (lane != 2'd0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ram_dbg_bridge.sv
// Debug-side RAM master: expands one debug command into per-beat jtag_*
// accesses. Reads answer per beat; writes answer once after the last beat.
// Writes stall while the LSU is writing the RAM.
module ram_dbg_bridge
   import ram_dbg_pkg::*;
#(
   parameter int unsigned RAM_DEPTH = 4096,
   parameter int unsigned LEN_W     = 8
)(
   input  logic            clk_i,
   input  logic            rst_i,
   ram_dbg_bridge_if.slave bus
);

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * RAM_DEPTH);

   state_e           state, state_nx;
   logic             we_q, we_nx;
   logic [31:0]      addr_q, addr_nx;
   logic [31:0]      wdata_q, wdata_nx;
   size_e            size_q, size_nx;
   logic [LEN_W-1:0] cnt_q, cnt_nx;
   logic [31:0]      rdata_q, rdata_nx;
   logic             err_q, err_nx;
   logic             last_q, last_nx;

   logic [3:0]       lane_sel;
   logic [31:0]      lane_wdata;
   logic [31:0]      lane_rdata;
   logic             lane_misalign;
   logic             bad;

   ram_dbg_lane u_lane (
      .size     (size_q),
      .lane     (addr_q[1:0]),
      .wdata_in (wdata_q),
      .rword    (bus.jtag_data_i),
      .sel      (lane_sel),
      .wdata    (lane_wdata),
      .rdata    (lane_rdata),
      .misalign (lane_misalign)
   );

   // State and command context registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_B;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         we_q    <= we_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         size_q  <= size_nx;
         cnt_q   <= cnt_nx;
         rdata_q <= rdata_nx;
         err_q   <= err_nx;
         last_q  <= last_nx;
      end
   end

   // Next-state, beat sequencing and all port outputs.
   always_comb begin
      state_nx = state;
      we_nx    = we_q;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      size_nx  = size_q;
      cnt_nx   = cnt_q;
      rdata_nx = rdata_q;
      err_nx   = err_q;
      last_nx  = last_q;

      bus.cmd_ready_o = 1'b0;
      bus.rsp_valid_o = 1'b0;
      bus.rsp_rdata_o = '0;
      bus.rsp_err_o   = 1'b0;
      bus.rsp_last_o  = 1'b0;
      bus.busy_o      = (state != IDLE);
      bus.jtag_ce_o   = 1'b0;
      bus.jtag_we_o   = 1'b0;
      bus.jtag_sel_o  = '0;
      bus.jtag_addr_o = '0;
      bus.jtag_data_o = '0;

      bad = (size_q == SZ_BAD) || lane_misalign || (addr_q >= ADDR_LIMIT);

      case (state)
         IDLE: begin
            bus.cmd_ready_o = 1'b1;
            if (bus.cmd_valid_i) begin
               we_nx    = bus.cmd_we_i;
               addr_nx  = bus.cmd_addr_i;
               wdata_nx = bus.cmd_wdata_i;
               size_nx  = size_e'(bus.cmd_size_i);
               // Without auto-increment the burst collapses to one beat.
               cnt_nx   = bus.cmd_autoinc_i ? bus.cmd_len_i : '0;
               state_nx = ISSUE;
            end
         end

         ISSUE: begin
            if (bad) begin
               rdata_nx = '0;
               err_nx   = 1'b1;
               last_nx  = 1'b1;
               state_nx = RESP;
            end else begin
               bus.jtag_ce_o   = 1'b1;
               bus.jtag_we_o   = we_q;
               bus.jtag_sel_o  = lane_sel;
               bus.jtag_addr_o = {addr_q[31:2], 2'b00};
               bus.jtag_data_o = we_q ? lane_wdata : '0;
               if (!we_q) begin
                  rdata_nx = bus.jtag_rvalid_i ? lane_rdata : '0;
                  err_nx   = 1'b0;
                  last_nx  = (cnt_q == '0);
                  state_nx = RESP;
               end else if (!bus.lsu_wr_i) begin
                  // Write beats chain directly; only the final one responds.
                  if (cnt_q == '0) begin
                     rdata_nx = '0;
                     err_nx   = 1'b0;
                     last_nx  = 1'b1;
                     state_nx = RESP;
                  end else begin
                     addr_nx = addr_q + size_step(size_q);
                     cnt_nx  = cnt_q - 1'b1;
                  end
               end
            end
         end

         RESP: begin
            bus.rsp_valid_o = 1'b1;
            bus.rsp_rdata_o = rdata_q;
            bus.rsp_err_o   = err_q;
            bus.rsp_last_o  = last_q;
            if (bus.rsp_ready_i) begin
               if (last_q) begin
                  state_nx = IDLE;
               end else begin
                  addr_nx  = addr_q + size_step(size_q);
                  cnt_nx   = cnt_q - 1'b1;
                  state_nx = ISSUE;
               end
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule
